// File: rtl/ps2_pkg.sv
// Shared definitions for the device-side PS/2 port: FSM states, frame sizes,
// reply codes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE, WAIT_IDLE, TX_HI, TX_LO, INHIBIT, RX_HI, RX_LO, ACK_HI, ACK_LO
    } ps2_state_e;

    localparam int TX_BITS = 11;
    localparam int RX_BITS = 10;

    localparam logic [7:0] CODE_ACK = 8'hFA;
    localparam logic [7:0] CODE_ERR = 8'hFE;
    localparam logic [7:0] CODE_BAT = 8'hAA;
    localparam logic [7:0] CODE_RST = 8'hFF;

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Wire order, bit 0 first: start 0, data LSB first, parity, stop 1.
    function automatic logic [TX_BITS-1:0] tx_frame(input logic [7:0] d);
        return {1'b1, odd_par(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_dev_port_if.sv
// Byte-level handshake between the PS/2 device port (slave) and its user (master).
interface ps2_dev_port_if;
    logic [7:0] tx_data_i;
    logic       tx_v_i;
    logic       tx_deq_o;
    logic [7:0] rx_code_o;
    logic       rx_v_o;
    logic       rx_perr_o;
    logic       busy_o;

    modport master (output tx_data_i, tx_v_i,
                    input  tx_deq_o, rx_code_o, rx_v_o, rx_perr_o, busy_o);
    modport slave  (input  tx_data_i, tx_v_i,
                    output tx_deq_o, rx_code_o, rx_v_o, rx_perr_o, busy_o);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 CLK and DATA pins; resets to idle-high.
module ps2_line_sync (
    input  logic clk6x,
    input  logic resetn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s
);
    logic [1:0] clk_ff, data_ff;

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk};
            data_ff <= {data_ff[0], ps2_data};
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
endmodule

// File: rtl/ps2_dev_port.sv
// Device-side PS/2 port: clocks device-to-host frames out and host commands in.
// PS2DEV_AUTOACK_EN: answer host bytes internally with FA/FE (and AA after FF).
module ps2_dev_port
    import ps2_pkg::*;
#(
    parameter int HALFBIT_US = 40,
    parameter int IDLE_US    = 50
) (
    input  logic clk6x,
    input  logic resetn,
    input  logic ck1us,
    input  logic PS2_CLK,
    input  logic PS2_DATA,
    output logic PS2_CLKDR0,
    output logic PS2_DATADR0,
    ps2_dev_port_if.slave bus
);
    localparam int TMR_MAX = (HALFBIT_US > IDLE_US) ? HALFBIT_US : IDLE_US;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    ps2_state_e          state, state_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic [3:0]          bitcnt, bitcnt_n;
    logic [TX_BITS-1:0]  tx_frm, tx_frm_n;
    logic [RX_BITS-1:0]  rx_sh, rx_sh_n;
    logic                clk_dr, clk_dr_n, data_dr, data_dr_n;
    logic [7:0]          rx_code, rx_code_n;
    logic                tx_deq, tx_deq_n, rx_v, rx_v_n, rx_perr, rx_perr_n;
    logic                busy, busy_n;
    logic                clk_s, data_s;
    logic                tx_pend, half_done, mid_hit, rx_ok;
    logic [7:0]          tx_byte;

    ps2_line_sync u_sync (
        .clk6x   (clk6x),
        .resetn  (resetn),
        .ps2_clk (PS2_CLK),
        .ps2_data(PS2_DATA),
        .clk_s   (clk_s),
        .data_s  (data_s)
    );

`ifdef PS2DEV_AUTOACK_EN
    logic [1:0] aq_cnt, aq_cnt_n;
    logic [7:0] aq0, aq0_n, aq1, aq1_n;
    logic       src_auto, src_auto_n;

    // Internal replies go out ahead of any external byte.
    assign tx_pend = bus.tx_v_i || (aq_cnt != 2'd0);
    assign tx_byte = (aq_cnt != 2'd0) ? aq0 : bus.tx_data_i;
`else
    assign tx_pend = bus.tx_v_i;
    assign tx_byte = bus.tx_data_i;
`endif

    assign half_done = ck1us && (tmr == TMR_W'(HALFBIT_US - 1));
    assign mid_hit   = ck1us && (tmr == TMR_W'(HALFBIT_US / 2 - 1));
    assign rx_ok     = rx_sh[9] && (rx_sh[8] == odd_par(rx_sh[7:0]));

    always_comb begin
        state_n   = state;
        tmr_n     = ck1us ? tmr + 1'b1 : tmr;
        bitcnt_n  = bitcnt;
        tx_frm_n  = tx_frm;
        rx_sh_n   = rx_sh;
        clk_dr_n  = clk_dr;
        data_dr_n = data_dr;
        rx_code_n = rx_code;
        tx_deq_n  = 1'b0;
        rx_v_n    = 1'b0;
        rx_perr_n = 1'b0;
`ifdef PS2DEV_AUTOACK_EN
        aq_cnt_n   = aq_cnt;
        aq0_n      = aq0;
        aq1_n      = aq1;
        src_auto_n = src_auto;
`endif
        unique case (state)
            IDLE: begin
                tmr_n     = '0;
                clk_dr_n  = 1'b0;
                data_dr_n = 1'b0;
                if (!clk_s)       state_n = INHIBIT;
                else if (tx_pend) state_n = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!clk_s) begin
                    state_n = INHIBIT;
                end else if (!data_s) begin
                    state_n  = RX_HI;
                    tmr_n    = '0;
                    bitcnt_n = '0;
                end else if (ck1us && tmr == TMR_W'(IDLE_US - 1)) begin
                    state_n  = TX_HI;
                    tmr_n    = '0;
                    bitcnt_n = '0;
                    tx_frm_n = tx_frame(tx_byte);
`ifdef PS2DEV_AUTOACK_EN
                    src_auto_n = (aq_cnt != 2'd0);
`endif
                end
            end
            TX_HI: begin
                // Our own CLK release needs a couple of cycles to reach clk_s,
                // so host inhibit is only trusted a full microsecond in.
                if (bitcnt != 4'd0 && tmr >= TMR_W'(2) && !clk_s) begin
                    state_n   = INHIBIT;
                    clk_dr_n  = 1'b0;
                    data_dr_n = 1'b0;
                end else begin
                    if (mid_hit) data_dr_n = ~tx_frm[0];
                    if (half_done) begin
                        state_n  = TX_LO;
                        tmr_n    = '0;
                        clk_dr_n = 1'b1;
                    end
                end
            end
            TX_LO: begin
                if (half_done) begin
                    tmr_n    = '0;
                    clk_dr_n = 1'b0;
                    if (bitcnt == 4'(TX_BITS - 1)) begin
                        state_n   = IDLE;
                        data_dr_n = 1'b0;
`ifdef PS2DEV_AUTOACK_EN
                        if (src_auto) begin
                            aq0_n    = aq1;
                            aq_cnt_n = aq_cnt - 2'd1;
                        end
                        tx_deq_n = !src_auto;
`else
                        tx_deq_n = 1'b1;
`endif
                    end else begin
                        state_n  = TX_HI;
                        bitcnt_n = bitcnt + 1'b1;
                        tx_frm_n = tx_frm >> 1;
                    end
                end
            end
            INHIBIT: begin
                clk_dr_n  = 1'b0;
                data_dr_n = 1'b0;
                tmr_n     = '0;
                bitcnt_n  = '0;
                if (clk_s) state_n = data_s ? IDLE : RX_HI;
            end
            RX_HI: begin
                if (half_done) begin
                    rx_sh_n  = {data_s, rx_sh[RX_BITS-1:1]};
                    state_n  = RX_LO;
                    tmr_n    = '0;
                    clk_dr_n = 1'b1;
                end
            end
            RX_LO: begin
                if (half_done) begin
                    tmr_n    = '0;
                    clk_dr_n = 1'b0;
                    if (bitcnt == 4'(RX_BITS - 1)) begin
                        state_n = ACK_HI;
                    end else begin
                        state_n  = RX_HI;
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
            ACK_HI: begin
                if (mid_hit && rx_ok) data_dr_n = 1'b1;
                if (half_done) begin
                    state_n  = ACK_LO;
                    tmr_n    = '0;
                    clk_dr_n = 1'b1;
                end
            end
            ACK_LO: begin
                if (half_done) begin
                    state_n   = IDLE;
                    tmr_n     = '0;
                    clk_dr_n  = 1'b0;
                    data_dr_n = 1'b0;
                    if (rx_ok) begin
                        rx_code_n = rx_sh[7:0];
                        rx_v_n    = 1'b1;
                    end else begin
                        rx_perr_n = 1'b1;
                    end
`ifdef PS2DEV_AUTOACK_EN
                    // A new host command supersedes any reply still queued.
                    aq0_n    = rx_ok ? CODE_ACK : CODE_ERR;
                    aq1_n    = CODE_BAT;
                    aq_cnt_n = (rx_ok && rx_sh[7:0] == CODE_RST) ? 2'd2 : 2'd1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state   <= IDLE;
            tmr     <= '0;
            bitcnt  <= '0;
            tx_frm  <= '0;
            rx_sh   <= '0;
            clk_dr  <= 1'b0;
            data_dr <= 1'b0;
            rx_code <= 8'h00;
            tx_deq  <= 1'b0;
            rx_v    <= 1'b0;
            rx_perr <= 1'b0;
            busy    <= 1'b0;
`ifdef PS2DEV_AUTOACK_EN
            aq_cnt   <= 2'd0;
            aq0      <= 8'h00;
            aq1      <= 8'h00;
            src_auto <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            bitcnt  <= bitcnt_n;
            tx_frm  <= tx_frm_n;
            rx_sh   <= rx_sh_n;
            clk_dr  <= clk_dr_n;
            data_dr <= data_dr_n;
            rx_code <= rx_code_n;
            tx_deq  <= tx_deq_n;
            rx_v    <= rx_v_n;
            rx_perr <= rx_perr_n;
            busy    <= busy_n;
`ifdef PS2DEV_AUTOACK_EN
            aq_cnt   <= aq_cnt_n;
            aq0      <= aq0_n;
            aq1      <= aq1_n;
            src_auto <= src_auto_n;
`endif
        end
    end

    assign PS2_CLKDR0    = clk_dr;
    assign PS2_DATADR0   = data_dr;
    assign bus.tx_deq_o  = tx_deq;
    assign bus.rx_code_o = rx_code;
    assign bus.rx_v_o    = rx_v;
    assign bus.rx_perr_o = rx_perr;
    assign bus.busy_o    = busy;
endmodule

// File: tb/tb_ps2_dev_port.sv
// Directed bench for ps2_dev_port: host-side line model, open-drain wiring,
// ck1us every 4 clk6x so one bit period is 320 cycles.
module tb_ps2_dev_port;
    logic clk6x = 1'b0;
    logic resetn = 1'b0;
    logic ck1us = 1'b0;
    logic host_clk_lo = 1'b0;
    logic host_data_lo = 1'b0;
    logic clkdr, datadr, pin_clk, pin_data;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, deq_cnt = 0, rxv_cnt = 0, perr_cnt = 0;

    ps2_dev_port_if bus ();

    ps2_dev_port dut (
        .clk6x      (clk6x),
        .resetn     (resetn),
        .ck1us      (ck1us),
        .PS2_CLK    (pin_clk),
        .PS2_DATA   (pin_data),
        .PS2_CLKDR0 (clkdr),
        .PS2_DATADR0(datadr),
        .bus        (bus)
    );

    assign pin_clk  = ~(clkdr | host_clk_lo);
    assign pin_data = ~(datadr | host_data_lo);

    always #10 clk6x = ~clk6x;

    initial forever begin
        repeat (3) @(posedge clk6x);
        #1 ck1us = 1'b1;
        @(posedge clk6x);
        #1 ck1us = 1'b0;
    end

    always @(posedge clk6x) begin
        cyc <= cyc + 1;
        if (bus.tx_deq_o)  deq_cnt  <= deq_cnt + 1;
        if (bus.rx_v_o)    rxv_cnt  <= rxv_cnt + 1;
        if (bus.rx_perr_o) perr_cnt <= perr_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit expected end of test");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_edge(input logic lvl, output bit seen);
        logic last;
        last = pin_clk;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk6x);
            if (pin_clk == lvl && last != lvl) seen = 1'b1;
            last = pin_clk;
        end
    endtask

    // Host receiver: data is taken at each CLK fall, bit 0 = start.
    task automatic host_get_frame(output logic [10:0] bits, output int t0,
                                  output int span, output bit ok);
        bit e;
        bits = '0; t0 = 0; span = 0; ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wait_edge(1'b0, e);
            if (!e) begin
                ok = 1'b0;
                break;
            end
            bits[i] = pin_data;
            if (i == 0) t0 = cyc;
            span = cyc - t0;
        end
    endtask

    task automatic drop_on_deq(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 8000 && !seen; n++) begin
            @(negedge clk6x);
            if (bus.tx_deq_o) seen = 1'b1;
        end
        bus.tx_v_i = 1'b0;
    endtask

    // Host request-to-send, then one data bit presented per device clock.
    task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                             output logic ack, output bit ok);
        logic [9:0] f;
        bit e;
        f = {stop, par, d};
        ok = 1'b1;
        host_clk_lo = 1'b1;
        repeat (400) @(negedge clk6x);
        host_data_lo = 1'b1;
        repeat (20) @(negedge clk6x);
        host_clk_lo = 1'b0;
        repeat (20) @(negedge clk6x);
        for (int i = 0; i < 10; i++) begin
            host_data_lo = ~f[i];
            wait_edge(1'b0, e);
            ok &= e;
        end
        host_data_lo = 1'b0;
        wait_edge(1'b0, e);
        ok &= e;
        ack = ~pin_data;
        wait_edge(1'b1, e);
        ok &= e;
        repeat (4) @(negedge clk6x);
    endtask

    initial begin
        logic [10:0] bits;
        int t0, span, trel, d0, v0, p0;
        bit ok, seen;
        logic ack;

        bus.tx_data_i = 8'h00;
        bus.tx_v_i    = 1'b0;
        repeat (4) @(posedge clk6x);
        @(negedge clk6x);
        chk("rst_clkdr",   clkdr, 0);
        chk("rst_datadr",  datadr, 0);
        chk("rst_deq",     bus.tx_deq_o, 0);
        chk("rst_code",    bus.rx_code_o, 8'h00);
        chk("rst_rxv",     bus.rx_v_o, 0);
        chk("rst_perr",    bus.rx_perr_o, 0);
        chk("rst_busy",    bus.busy_o, 0);
        resetn = 1'b1;
        repeat (10) @(negedge clk6x);

        // 0x1C: start 0, 0011 1000 LSB first, parity 0, stop 1.
        d0 = deq_cnt;
        bus.tx_data_i = 8'h1C;
        bus.tx_v_i    = 1'b1;
        fork
            host_get_frame(bits, t0, span, ok);
            drop_on_deq(seen);
        join
        chk("tx1c_ok",    ok, 1);
        chk("tx1c_bits",  bits, 11'h438);
        chk("tx1c_span",  span, 3200);
        chk("tx1c_deq",   seen, 1);
        repeat (4) @(negedge clk6x);
        chk("tx1c_ndeq",  deq_cnt - d0, 1);
        repeat (100) @(negedge clk6x);

        // 0x5A aborted by host inhibit in bit 4, then resent in full.
        d0 = deq_cnt;
        bus.tx_data_i = 8'h5A;
        bus.tx_v_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_edge(1'b0, ok);
            chk("ab_fall", ok, 1);
        end
        wait_edge(1'b1, ok);
        chk("ab_rise", ok, 1);
        repeat (60) @(negedge clk6x);
        host_clk_lo = 1'b1;
        repeat (3) @(posedge clk6x);
        @(negedge clk6x);
        chk("ab_clkdr",  clkdr, 0);
        chk("ab_datadr", datadr, 0);
        chk("ab_busy",   bus.busy_o, 1);
        repeat (400) @(negedge clk6x);
        chk("ab_nodeq",  deq_cnt - d0, 0);
        host_clk_lo = 1'b0;
        trel = cyc;
        fork
            host_get_frame(bits, t0, span, ok);
            drop_on_deq(seen);
        join
        chk("ab_ok",     ok, 1);
        chk("ab_bits",   bits, 11'h6B4);
        chk("ab_gap",    (t0 - trel >= 350) && (t0 - trel <= 380), 1);
        chk("ab_deq",    seen, 1);
        repeat (100) @(negedge clk6x);

        // Host 0xED with correct parity (1).
        v0 = rxv_cnt; p0 = perr_cnt;
        host_send(8'hED, 1'b1, 1'b1, ack, ok);
        chk("rxed_ok",   ok, 1);
        chk("rxed_ack",  ack, 1);
        chk("rxed_code", bus.rx_code_o, 8'hED);
        chk("rxed_v",    rxv_cnt - v0, 1);
        chk("rxed_perr", perr_cnt - p0, 0);
`ifdef PS2DEV_AUTOACK_EN
        host_get_frame(bits, t0, span, ok);
        chk("rxed_reply", bits, 11'h7F4);
`endif
        repeat (100) @(negedge clk6x);

        // Host 0xED with wrong parity.
        v0 = rxv_cnt; p0 = perr_cnt;
        host_send(8'hED, 1'b0, 1'b1, ack, ok);
        chk("bp_ok",     ok, 1);
        chk("bp_ack",    ack, 0);
        chk("bp_perr",   perr_cnt - p0, 1);
        chk("bp_v",      rxv_cnt - v0, 0);
`ifdef PS2DEV_AUTOACK_EN
        host_get_frame(bits, t0, span, ok);
        chk("bp_reply", bits, 11'h5FC);
`endif
        repeat (100) @(negedge clk6x);

        // Host 0x12, good parity but stop bit 0: code must stay 0xED.
        v0 = rxv_cnt; p0 = perr_cnt;
        host_send(8'h12, 1'b1, 1'b0, ack, ok);
        chk("bs_ok",     ok, 1);
        chk("bs_ack",    ack, 0);
        chk("bs_perr",   perr_cnt - p0, 1);
        chk("bs_v",      rxv_cnt - v0, 0);
        chk("bs_code",   bus.rx_code_o, 8'hED);
`ifdef PS2DEV_AUTOACK_EN
        host_get_frame(bits, t0, span, ok);
        chk("bs_reply", bits, 11'h5FC);
        repeat (100) @(negedge clk6x);

        // Host reset command: FA then AA, neither dequeues.
        d0 = deq_cnt;
        host_send(8'hFF, 1'b1, 1'b1, ack, ok);
        chk("ff_ack",   ack, 1);
        host_get_frame(bits, t0, span, ok);
        chk("ff_fa",    bits, 11'h7F4);
        host_get_frame(bits, t0, span, ok);
        chk("ff_aa",    bits, 11'h754);
        repeat (200) @(negedge clk6x);
        chk("ff_nodeq", deq_cnt - d0, 0);
`endif
        repeat (100) @(negedge clk6x);

        // Reset in TX_LO of bit 1 (d0 of 0x1C = 0, so DATA is driven).
        bus.tx_data_i = 8'h1C;
        bus.tx_v_i    = 1'b1;
        wait_edge(1'b0, ok);
        wait_edge(1'b0, seen);
        chk("rs_falls",  ok && seen, 1);
        chk("rs_pre_dr", {clkdr, datadr}, 2'b11);
        resetn = 1'b0;
        @(posedge clk6x);
        #1;
        chk("rs_clkdr",  clkdr, 0);
        chk("rs_datadr", datadr, 0);
        chk("rs_busy",   bus.busy_o, 0);
        bus.tx_v_i = 1'b0;
        repeat (3) @(negedge clk6x);
        resetn = 1'b1;
        repeat (20) @(negedge clk6x);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_dev_port.md
# ps2_dev_port

Device-side PS/2 port: the keyboard/mouse end of the PS/2 link, complementing the host controller on the NORA FPGA. It generates the PS/2 clock, transmits device-to-host frames from a one-byte handshake source, and detects host request-to-send so it can clock in, check and acknowledge host command bytes. Its uses are in-FPGA loopback tests of the host controller and emulating a keyboard toward an external host. It runs in the clk6x domain and takes bit timing from the shared ck1us pulse.

## Interface
- HALFBIT_US, 40: duration of CLK low and of CLK high phase in µs (12.5 kHz bit rate).
- IDLE_US, 50: both lines must be high for this long before a device-to-host frame starts.
- clk6x  in  1  48 MHz system clock.
- resetn  in  1  reset, synchronous, active-low; clock clk6x.
- ck1us  in  1  1T pulse every 1 µs.
- PS2_CLK, PS2_DATA  in  1 each  pin values (asynchronous).
- PS2_CLKDR0, PS2_DATADR0  out  1 each  1 = drive line low, 0 = release (HiZ).
- tx_data_i  in  8  byte to send to host.
- tx_v_i  in  1  tx_data_i valid; hold data stable until tx_deq_o.
- tx_deq_o  out  1  1T pulse: byte fully delivered (stop bit done).
- rx_code_o  out  8  last host command byte; holds until next valid byte.
- rx_v_o  out  1  1T pulse: rx_code_o updated.
- rx_perr_o  out  1  1T pulse: host frame had bad parity or stop=0.
- busy_o  out  1  1 in any state except IDLE.

## Operation
- Pins are passed through a 2-FF synchronizer; the FSM sees only synchronized values.
- States: IDLE, WAIT_IDLE, TX_HI, TX_LO, INHIBIT, RX_HI, RX_LO, ACK_HI, ACK_LO.
- IDLE: if synced CLK=0 → INHIBIT. Otherwise, if a byte is pending → WAIT_IDLE. Host inhibit wins over a simultaneous tx_v_i.
- WAIT_IDLE: count ck1us while CLK=1 and DATA=1, restarting the count on any low. CLK=0 → INHIBIT. DATA=0 with CLK=1 → RX_HI. Count reaches IDLE_US → TX_HI with bitcnt=0.
- TX frame (11 bits): start 0, data LSB first, odd parity, stop 1.
  - TX_HI: at HALFBIT_US/2, set DATADR0 = ~bit. At HALFBIT_US → TX_LO.
  - TX_LO: CLKDR0=1 for HALFBIT_US, then bitcnt+1.
  - After bit 10, release both lines, pulse tx_deq_o, go to IDLE.
- Abort: in TX_HI after bit 0, synced CLK=0 while CLKDR0=0 means the host is inhibiting. Release both lines, go to INHIBIT, and do not dequeue; the byte is retried in full later.
- INHIBIT: lines released. Wait for CLK=1. Then DATA=0 → RX_HI; DATA=1 → IDLE.
- RX (10 bits: 8 data, parity, stop).
  - RX_HI: sample DATA at the end of the HALFBIT_US high phase.
  - RX_LO: drive CLK low for HALFBIT_US.
  - After the stop bit → ACK_HI.
- ACK: in ACK_HI drive DATA low at HALFBIT_US/2, then ACK_LO pulses CLK, then release both lines.
  - Frame good (odd parity, stop=1): load rx_code_o, pulse rx_v_o.
  - Otherwise: pulse rx_perr_o, no ACK drive (DATA stays released), rx_code_o unchanged.
  - Then IDLE.
- Parity is computed as the XOR-reduce of the data bits, inverted.

## Timing
- Reset values: PS2_CLKDR0=0, PS2_DATADR0=0, tx_deq_o=0, rx_code_o=8'h00, rx_v_o=0, rx_perr_o=0, busy_o=0; FSM in IDLE.
- Reset asserted mid-frame releases both lines on the next clk6x edge.
- Pin-to-FSM latency: 2 clk6x. Phase timers are counted in ck1us pulses, so jitter is ≤1 µs.
- Each bit takes 2·HALFBIT_US µs. A TX frame takes IDLE_US + 11·2·HALFBIT_US µs.
- rx_v_o / rx_perr_o assert in the cycle the ACK_LO phase ends.
- tx_deq_o asserts in the cycle the stop-bit low phase ends.

## Configuration
- PS2DEV_AUTOACK_EN defined: on a good host byte, the device internally queues 0xFA (0xFE on error). This reply is sent before any external tx byte, and tx_deq_o does not pulse for it. A host byte of 0xFF (reset) additionally queues 0xAA after 0xFA.
- Undefined: no automatic replies; only external bytes are sent.

## Structure
- Shared package ps2_pkg: FSM state enum, frame bit counts (TX_BITS=11, RX_BITS=10), ACK/ERR/BAT codes 8'hFA/8'hFE/8'hAA.
- Sub-module ps2_line_sync: 2-FF synchronizer for CLK and DATA.

## Test plan
- tx_data_i=0x1C, tx_v_i=1, host idle → 11 frame bits 0,00111000,0,1 with 80 µs per bit; tx_deq_o 1T after stop.
- Host pulls CLK low during bit 4 of 0x5A → lines released within 3 clk6x, no tx_deq_o; after release and 50 µs idle, 0x5A is resent in full.
- Host RTS with 0xED, correct parity → device ACK low during the 11th clock; rx_code_o=0xED, rx_v_o 1T.
- Host RTS with 0xED and wrong parity → no ACK, rx_perr_o 1T, rx_code_o unchanged; with PS2DEV_AUTOACK_EN, device sends 0xFE.
- PS2DEV_AUTOACK_EN, host sends 0xFF → device sends 0xFA then 0xAA; tx_deq_o never pulses.
- Reset asserted in TX_LO → both DR outputs 0 the next cycle, busy_o=0.
